// File: rtl/mtpsa_pkg.sv
// Shared constants and types for the MTPSA user-pipeline merge logic.
// Holds user count, tuser field widths and the arbiter state encoding.
package mtpsa_pkg;

    localparam int MTPSA_NUM_USERS    = 8;
    localparam int MTPSA_TUSER_META_W = 40;
    localparam int MTPSA_DIGEST_W     = 256;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mtpsa_rr_pick.sv
// Rotate-priority picker: first set bit of req searching upward from
// last_grant+1 with wrap. Ports: req, last_grant in; idx, any_valid out.
module mtpsa_rr_pick #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] idx,
    output logic          any_valid
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        sum       = '0;
        cand      = '0;
        // last_grant < N and k <= N, so one conditional subtract wraps.
        for (int k = 1; k <= N; k++) begin
            sum = {1'b0, last_grant} + (IW + 1)'(k);
            if (sum >= (IW + 1)'(N))
                sum = sum - (IW + 1)'(N);
            cand = sum[IW-1:0];
            if (!any_valid && req[cand]) begin
                any_valid = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/mtpsa_user_arbiter.sv
// Packet-granular round-robin merge of per-user AXI4-Stream pipelines.
// Ports: s_axis_* (NUM_USERS packed slices), m_axis_*, grant_idx, pkt_cnt.
// Define MTPSA_ARB_PKT_CNT_EN to build per-user 32-bit packet counters.
module mtpsa_user_arbiter
    import mtpsa_pkg::*;
#(
    parameter int NUM_USERS   = MTPSA_NUM_USERS,
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = MTPSA_TUSER_META_W + MTPSA_DIGEST_W,
    parameter int IDX_WIDTH   = $clog2(NUM_USERS)
) (
    input  logic                              clk_line,
    input  logic                              clk_line_rst,
    input  logic [NUM_USERS*DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [NUM_USERS*DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [NUM_USERS*TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic [NUM_USERS-1:0]              s_axis_tvalid,
    input  logic [NUM_USERS-1:0]              s_axis_tlast,
    output logic [NUM_USERS-1:0]              s_axis_tready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]           m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]            m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [IDX_WIDTH-1:0]              grant_idx,
    output logic [NUM_USERS*32-1:0]           pkt_cnt
);

    localparam int KW = DATA_WIDTH / 8;

    arb_state_e           state_q;
    arb_state_e           state_d;
    logic [IDX_WIDTH-1:0] grant_q;
    logic [IDX_WIDTH-1:0] last_grant_q;
    logic [IDX_WIDTH-1:0] pick_idx;
    logic                 any_valid;
    logic                 hs_last;

    mtpsa_rr_pick #(
        .N  (NUM_USERS),
        .IW (IDX_WIDTH)
    ) u_pick (
        .req        (s_axis_tvalid),
        .last_grant (last_grant_q),
        .idx        (pick_idx),
        .any_valid  (any_valid)
    );

    assign hs_last   = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign grant_idx = grant_q;

    always_ff @(posedge clk_line) begin
        if (clk_line_rst)
            state_q <= ARB_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: if (any_valid) state_d = ARB_BUSY;
            ARB_BUSY: if (hs_last)   state_d = ARB_IDLE;
            default:                 state_d = ARB_IDLE;
        endcase
    end

    // Reset last_grant to the top user so user 0 wins the first round.
    always_ff @(posedge clk_line) begin
        if (clk_line_rst) begin
            grant_q      <= '0;
            last_grant_q <= IDX_WIDTH'(NUM_USERS - 1);
        end else begin
            if (state_q == ARB_IDLE && any_valid)
                grant_q <= pick_idx;
            if (hs_last)
                last_grant_q <= grant_q;
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
        if (state_q == ARB_BUSY) begin
            m_axis_tdata  = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tkeep  = s_axis_tkeep[grant_q*KW +: KW];
            m_axis_tuser  = s_axis_tuser[grant_q*TUSER_WIDTH +: TUSER_WIDTH];
            m_axis_tvalid = s_axis_tvalid[grant_q];
            m_axis_tlast  = s_axis_tlast[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
        end
    end

`ifdef MTPSA_ARB_PKT_CNT_EN
    logic [NUM_USERS*32-1:0] cnt_q;

    always_ff @(posedge clk_line) begin
        if (clk_line_rst)
            cnt_q <= '0;
        else if (hs_last)
            cnt_q[grant_q*32 +: 32] <= cnt_q[grant_q*32 +: 32] + 32'd1;
    end

    assign pkt_cnt = cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_mtpsa_user_arbiter.sv
// Directed self-checking bench for mtpsa_user_arbiter (8 users, 256-bit).
// Inputs change and outputs are sampled around the falling clock edge.
module tb_mtpsa_user_arbiter;

    localparam int NU = 8;
    localparam int DW = 256;
    localparam int KW = DW / 8;
    localparam int TW = 296;
    localparam int IW = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NU*DW-1:0]  s_tdata  = '0;
    logic [NU*KW-1:0]  s_tkeep  = '0;
    logic [NU*TW-1:0]  s_tuser  = '0;
    logic [NU-1:0]     s_tvalid = '0;
    logic [NU-1:0]     s_tlast  = '0;
    logic [NU-1:0]     s_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tkeep;
    logic [TW-1:0]     m_tuser;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready = 1'b1;
    logic [IW-1:0]     grant_idx;
    logic [NU*32-1:0]  pkt_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mtpsa_user_arbiter dut (
        .clk_line      (clk),
        .clk_line_rst  (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tuser  (s_tuser),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready),
        .grant_idx     (grant_idx),
        .pkt_cnt       (pkt_cnt)
    );

    function automatic logic [DW-1:0] dat(input int u, input int b);
        return {8{u[7:0], b[7:0], 16'hA5C3}};
    endfunction

    function automatic logic [KW-1:0] kp(input int u, input int b);
        return {u[7:0] ^ 8'h5A, b[7:0], 16'hF0F0};
    endfunction

    function automatic logic [TW-1:0] usr(input int u, input int b);
        return {u[7:0], b[7:0], 24'h123456, ~dat(u, b)};
    endfunction

    task automatic drive(input int u, input logic v,
                         input logic l, input int b);
        s_tdata[u*DW +: DW] = dat(u, b);
        s_tkeep[u*KW +: KW] = kp(u, b);
        s_tuser[u*TW +: TW] = usr(u, b);
        s_tvalid[u]         = v;
        s_tlast[u]          = l;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== '0) begin
            failures++;
            $display("FAIL reset_out got v=%b rdy=%h want v=0 rdy=00",
                     m_tvalid, s_tready);
        end
        checks++;
        if (grant_idx !== 3'd0 || pkt_cnt !== '0) begin
            failures++;
            $display("FAIL reset_regs got grant=%0d cnt=%h want 0 0",
                     grant_idx, pkt_cnt);
        end
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        drive(3, 1'b1, 1'b0, 0);
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== '0) begin
            failures++;
            $display("FAIL single_idle got v=%b rdy=%h want 0 00",
                     m_tvalid, s_tready);
        end
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk);
            drive(3, 1'b1, b == 3, b);
            if (b > 0) #1;
            else begin
                @(negedge clk);
                #1;
            end
            checks++;
            if (grant_idx !== 3'd3 || m_tvalid !== 1'b1 ||
                s_tready !== 8'h08) begin
                failures++;
                $display("FAIL single_ctl b=%0d got g=%0d v=%b rdy=%h want 3 1 08",
                         b, grant_idx, m_tvalid, s_tready);
            end
            checks++;
            if (m_tdata !== dat(3, b) || m_tkeep !== kp(3, b) ||
                m_tuser !== usr(3, b) || m_tlast !== (b == 3)) begin
                failures++;
                $display("FAIL single_data b=%0d got d=%h l=%b want d=%h l=%b",
                         b, m_tdata, m_tlast, dat(3, b), b == 3);
            end
        end
        @(negedge clk);
        drive(3, 1'b0, 1'b0, 0);
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== '0) begin
            failures++;
            $display("FAIL single_done got v=%b rdy=%h want 0 00",
                     m_tvalid, s_tready);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        @(negedge clk);
        for (int u = 0; u < NU; u++) drive(u, 1'b1, 1'b1, 0);
        for (int k = 0; k < 9; k++) begin
            #1;
            checks++;
            if (m_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL rr_bubble k=%0d got v=%b want 0", k, m_tvalid);
            end
            if (k == 8) begin
                checks++;
`ifdef MTPSA_ARB_PKT_CNT_EN
                if (pkt_cnt !== {8{32'd1}}) begin
`else
                if (pkt_cnt !== '0) begin
`endif
                    failures++;
                    $display("FAIL rr_cnt got %h", pkt_cnt);
                end
            end
            @(negedge clk);
            #1;
            checks++;
            if (m_tvalid !== 1'b1 || grant_idx !== IW'(k % NU) ||
                m_tdata !== dat(k % NU, 0) || m_tlast !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant k=%0d got g=%0d v=%b want g=%0d v=1",
                         k, grant_idx, m_tvalid, k % NU);
            end
            @(negedge clk);
        end
        s_tvalid = '0;
    endtask

    task automatic test_interleave();
        do_reset();
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 0);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk);
            drive(1, 1'b1, b == 4, b);
            if (b == 2) drive(0, 1'b1, 1'b1, 0);
            #1;
            checks++;
            if (grant_idx !== 3'd1 || m_tvalid !== 1'b1 ||
                s_tready !== 8'h02 || m_tdata !== dat(1, b) ||
                m_tlast !== (b == 4)) begin
                failures++;
                $display("FAIL ilv_beat b=%0d got g=%0d rdy=%h d=%h want g=1 rdy=02 d=%h",
                         b, grant_idx, s_tready, m_tdata, dat(1, b));
            end
        end
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 0);
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || s_tready !== '0) begin
            failures++;
            $display("FAIL ilv_gap got v=%b rdy=%h want 0 00",
                     m_tvalid, s_tready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (grant_idx !== 3'd0 || m_tvalid !== 1'b1 ||
            s_tready !== 8'h01 || m_tdata !== dat(0, 0)) begin
            failures++;
            $display("FAIL ilv_next got g=%0d v=%b rdy=%h want 0 1 01",
                     grant_idx, m_tvalid, s_tready);
        end
        @(negedge clk);
        s_tvalid = '0;
    endtask

    task automatic test_backpressure();
        int b;
        b = 0;
        do_reset();
        @(negedge clk);
        drive(5, 1'b1, 1'b0, 0);
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            m_tready = (c % 2 == 0);
            drive(5, 1'b1, b == 5, b);
            #1;
            checks++;
            if (s_tready !== {2'b00, m_tready, 5'b0} ||
                m_tvalid !== 1'b1 || m_tdata !== dat(5, b) ||
                m_tlast !== (b == 5)) begin
                failures++;
                $display("FAIL bp_beat c=%0d got rdy=%h d=%h want mready=%b d=%h",
                         c, s_tready, m_tdata, m_tready, dat(5, b));
            end
            if (m_tready) b++;
        end
        @(negedge clk);
        m_tready = 1'b1;
        drive(5, 1'b0, 1'b0, 0);
        #1;
        checks++;
        if (b !== 6 || m_tvalid !== 1'b0) begin
            failures++;
            $display("FAIL bp_done got hs=%0d v=%b want 6 0", b, m_tvalid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        @(negedge clk);
        drive(2, 1'b1, 1'b0, 0);
        drive(4, 1'b1, 1'b1, 0);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c >= 2 && c < 5) drive(2, 1'b0, 1'b0, 2);
            else drive(2, 1'b1, c == 6, (c < 2) ? c : c - 3);
            #1;
            checks++;
            if (grant_idx !== 3'd2 || s_tready[4] !== 1'b0 ||
                m_tvalid !== (c < 2 || c >= 5)) begin
                failures++;
                $display("FAIL stall c=%0d got g=%0d v=%b rdy=%h want g=2",
                         c, grant_idx, m_tvalid, s_tready);
            end
        end
        @(negedge clk);
        drive(2, 1'b0, 1'b0, 0);
        @(negedge clk);
        #1;
        checks++;
        if (grant_idx !== 3'd4 || m_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL stall_next got g=%0d v=%b want 4 1",
                     grant_idx, m_tvalid);
        end
        @(negedge clk);
        s_tvalid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 0);
        @(negedge clk);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 0);
        drive(6, 1'b1, 1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        drive(6, 1'b1, 1'b0, 1);
        #1;
        checks++;
        if (grant_idx !== 3'd6 || m_tvalid !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got g=%0d v=%b want 6 1",
                     grant_idx, m_tvalid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive(0, 1'b1, 1'b1, 0);
        #1;
        checks++;
        if (s_tready !== '0 || m_tvalid !== 1'b0 || pkt_cnt !== '0) begin
            failures++;
            $display("FAIL rstmid_post got rdy=%h v=%b cnt=%h want 00 0 0",
                     s_tready, m_tvalid, pkt_cnt);
        end
        @(negedge clk);
        #1;
        checks++;
        if (grant_idx !== 3'd0 || m_tvalid !== 1'b1 || s_tready !== 8'h01) begin
            failures++;
            $display("FAIL rstmid_grant got g=%0d rdy=%h want 0 01",
                     grant_idx, s_tready);
        end
        @(negedge clk);
        s_tvalid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_interleave();
        test_backpressure();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
